adder_arbiter: RTL

//  Round-robin arbiter/sequencer sharing one external signed Adder between NREQ requesters.

---
 rtl/adder_arbiter.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sequencer that shares one external signed Adder
// between NREQ requesters. One operand pair is accepted per grant, driven to
// the Adder from registers, and the sum is sampled ADDER_LAT cycles later and
// returned to the granted requester with a valid/ready handshake.
// Optional feature: define ADDER_ARB_OVF_EN to add the rsp_ovf signed-overflow
// output, registered alongside rsp_data.
module adder_arbiter #(
  parameter int NREQ      = 4,
  parameter int W         = 32,
  parameter int ADDER_LAT = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_in_0,
  input  logic [NREQ*W-1:0] req_in_1,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      adder_in_0,
  output logic [W-1:0]      adder_in_1,
  input  logic [W-1:0]      adder_out,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [W-1:0]      rsp_data,
  input  logic [NREQ-1:0]   rsp_ready
`ifdef ADDER_ARB_OVF_EN
  ,
  output logic              rsp_ovf
`endif
);

  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(ADDER_LAT + 2);
  localparam logic [GW-1:0] LAST_RST = GW'(NREQ - 1);
  localparam logic [CW-1:0] LAT_C    = CW'(ADDER_LAT);
  localparam logic [GW:0]   NREQ_C   = (GW+1)'(NREQ);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]      state_r;
  logic [CW-1:0]   cnt_r;
  logic [GW-1:0]   grant_r;
  logic [GW-1:0]   last_grant_r;
  logic [W-1:0]    adder_in_0_r;
  logic [W-1:0]    adder_in_1_r;
  logic [NREQ-1:0] rsp_valid_r;
  logic [W-1:0]    rsp_data_r;

  logic [GW-1:0]   pick_s;
  logic            pick_hit_s;
  logic            accept_s;
  logic            hs_s;
  logic [NREQ-1:0] req_ready_s;

  // Round-robin pick: scan from farthest to nearest so the requester closest
  // after last_grant overwrites any farther candidate.
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] cand;
    pick_s     = last_grant_r;
    pick_hit_s = 1'b0;
    sum        = '0;
    cand       = '0;
    for (int k = NREQ; k >= 1; k--) begin
      sum = {1'b0, last_grant_r} + (GW+1)'(k);
      if (sum >= NREQ_C) begin
        sum = sum - NREQ_C;
      end else begin
        sum = sum;
      end
      cand = sum[GW-1:0];
      if (req_valid[cand]) begin
        pick_s     = cand;
        pick_hit_s = 1'b1;
      end else begin
        pick_s     = pick_s;
      end
    end
  end

  // Accept pulse in IDLE, masked while reset is held so outputs stay at zero.
  always_comb begin
    accept_s = (state_r == ST_IDLE) && pick_hit_s && sys_rst_n;
    hs_s     = (state_r == ST_RESP) && rsp_ready[grant_r];
    if (accept_s) begin
      req_ready_s = NREQ'(1'b1) << pick_s;
    end else begin
      req_ready_s = '0;
    end
  end

  // Sequencer: grant, wait out the Adder latency, then hold the response.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= '0;
      grant_r      <= '0;
      last_grant_r <= LAST_RST;
      adder_in_0_r <= '0;
      adder_in_1_r <= '0;
      rsp_valid_r  <= '0;
      rsp_data_r   <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            grant_r      <= pick_s;
            adder_in_0_r <= req_in_0[pick_s*W +: W];
            adder_in_1_r <= req_in_1[pick_s*W +: W];
            cnt_r        <= '0;
            state_r      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_r == LAT_C) begin
            rsp_data_r  <= adder_out;
            rsp_valid_r <= NREQ'(1'b1) << grant_r;
            state_r     <= ST_RESP;
          end else begin
            cnt_r <= cnt_r + CW'(1);
          end
        end
        ST_RESP: begin
          if (hs_s) begin
            rsp_valid_r  <= '0;
            last_grant_r <= grant_r;
            state_r      <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          rsp_valid_r <= '0;
        end
      endcase
    end
  end

`ifdef ADDER_ARB_OVF_EN
  logic ovf_r;

  // Signed overflow: equal operand signs but result sign differs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ovf_r <= 1'b0;
    end else if ((state_r == ST_WAIT) && (cnt_r == LAT_C)) begin
      ovf_r <= (adder_in_0_r[W-1] == adder_in_1_r[W-1]) &&
               (adder_out[W-1] != adder_in_0_r[W-1]);
    end else if (hs_s) begin
      ovf_r <= 1'b0;
    end
  end

  assign rsp_ovf = ovf_r;
`endif

  assign req_ready  = req_ready_s;
  assign adder_in_0 = adder_in_0_r;
  assign adder_in_1 = adder_in_1_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;

endmodule
